// File: rtl/mfp_ahb_uart_tx.sv
// mfp_ahb_uart_tx: AHB-Lite zero-wait UART transmitter with a byte FIFO.
// Firmware pushes bytes through DATA, polls STATUS, and clears the sticky
// overflow flag through CTRL. Frames are 8N1, LSB first, and back-to-back
// frames are sent with no idle gap.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | line high, waiting for the FIFO to hold a byte
// ST_START | start bit (low) for one bit time
// ST_DATA  | data bits, shift[0] on the line, LSB first
// ST_STOP  | stop bit (high); chains straight into the next frame
module mfp_ahb_uart_tx #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_AW         = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        UART_TX,
    output logic        TX_BUSY
);

    localparam int DIV   = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int TW    = $clog2(DIV);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [TW-1:0]    DIV_M1  = TW'(DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Registered address phase
    logic               ap_valid_q, ap_valid_d;
    logic               ap_write_q, ap_write_d;
    logic [1:0]         ap_addr_q,  ap_addr_d;

    // FIFO
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;

    // Transmitter
    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;

    logic wr_data, wr_ctrl, rd_status;
    logic fifo_empty, fifo_full, push_ok, pop, bit_done;

    // Only HADDR[3:2], HTRANS[1] and HWDATA[7:0] carry meaning here.
    logic unused_bits;
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

    // Address-phase capture and data-phase decode
    always_comb begin
        ap_valid_d = HSEL & HTRANS[1];
        ap_write_d = HWRITE;
        ap_addr_d  = HADDR[3:2];
        wr_data    = ap_valid_q & ap_write_q & (ap_addr_q == 2'd0);
        wr_ctrl    = ap_valid_q & ap_write_q & (ap_addr_q == 2'd2) & HWDATA[0];
        rd_status  = ap_valid_q & ~ap_write_q & (ap_addr_q == 2'd1);
    end

    // FIFO bookkeeping; fullness is judged on the count at the start of the cycle,
    // so a same-cycle pop never makes room for a push
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        push_ok    = wr_data & ~fifo_full;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        if (push_ok) wptr_d = wptr_q + FIFO_AW'(1);
        if (pop)     rptr_d = rptr_q + FIFO_AW'(1);
        if (push_ok && !pop)      count_d = count_q + (FIFO_AW + 1)'(1);
        else if (!push_ok && pop) count_d = count_q - (FIFO_AW + 1)'(1);
        // a rejected push beats a simultaneous clear
        if (wr_data && fifo_full) ovf_d = 1'b1;
        else if (wr_ctrl)         ovf_d = 1'b0;
    end

    // Transmit FSM next-state; the bit timer counts down and each bit ends at zero
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        bit_done  = (timer_q == '0);
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    timer_d = DIV_M1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    timer_d   = DIV_M1;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    timer_d   = DIV_M1;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        timer_d = DIV_M1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the next state so the pin itself is a flop output
    always_comb begin
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Read mux: only a registered STATUS read returns non-zero data
    always_comb begin
        HRDATA = '0;
        if (rd_status) begin
            HRDATA[0]             = fifo_empty;
            HRDATA[1]             = fifo_full;
            HRDATA[2]             = (state_q != ST_IDLE);
            HRDATA[3]             = ovf_q;
            HRDATA[8+FIFO_AW:8]   = count_q;
        end
    end

    assign UART_TX = tx_q;
    assign TX_BUSY = (state_q != ST_IDLE) | ~fifo_empty;

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge HCLK) begin
        if (push_ok) mem_q[wptr_q] <= HWDATA[7:0];
    end

    // State registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid_q <= 1'b0;
            ap_write_q <= 1'b0;
            ap_addr_q  <= 2'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
        end else begin
            ap_valid_q <= ap_valid_d;
            ap_write_q <= ap_write_d;
            ap_addr_q  <= ap_addr_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_mfp_ahb_uart_tx.sv
// Directed bench for mfp_ahb_uart_tx with DIV = 16 and a 16-byte FIFO.
module tb_mfp_ahb_uart_tx;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL    = 1'b0;
    logic [31:0] HADDR   = '0;
    logic [1:0]  HTRANS  = 2'b00;
    logic        HWRITE  = 1'b0;
    logic [31:0] HWDATA  = '0;
    logic [31:0] HRDATA;
    logic        UART_TX;
    logic        TX_BUSY;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] wq[$];
    logic [31:0] rd;

    always #5 HCLK = ~HCLK;

    mfp_ahb_uart_tx #(
        .CLOCK_FREQUENCY(16),
        .BAUD_RATE      (1),
        .FIFO_AW        (4)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .HSEL   (HSEL),
        .HADDR  (HADDR),
        .HTRANS (HTRANS),
        .HWRITE (HWRITE),
        .HWDATA (HWDATA),
        .HRDATA (HRDATA),
        .UART_TX(UART_TX),
        .TX_BUSY(TX_BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected STATUS word for a given count / overflow / shifter state
    function automatic logic [31:0] st(input int cnt, input bit ovf, input bit act);
        logic [31:0] v;
        v = 32'(cnt) << 8;
        if (cnt == 0)  v[0] = 1'b1;
        if (cnt == 16) v[1] = 1'b1;
        v[2] = act;
        v[3] = ovf;
        return v;
    endfunction

    // Pipelined writes of every entry in wq to address a; returns 1ns after the
    // edge that ends the last data phase
    task automatic wr_burst(input logic [31:0] a, input logic sel);
        for (int i = 0; i < wq.size(); i++) begin
            HSEL = sel; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
            if (i > 0) HWDATA = wq[i-1];
            @(posedge HCLK); #1;
        end
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
        HWDATA = wq[wq.size()-1];
        @(posedge HCLK); #1;
        HWDATA = '0;
    endtask

    // Single read; d is sampled in the data phase
    task automatic bus_rd(input logic [31:0] a, input logic sel, input logic [1:0] tr,
                          output logic [31:0] d);
        HSEL = sel; HTRANS = tr; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
        d = HRDATA;
    endtask

    // Called 1ns after a start edge; checks the first and last cycle of every bit cell
    task automatic chk_frame(input logic [7:0] b, input string tag);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("%s_cell%0d_first", tag, i), {31'd0, UART_TX}, {31'd0, bits[i]});
            repeat (15) @(posedge HCLK);
            #1;
            chk($sformatf("%s_cell%0d_last", tag, i), {31'd0, UART_TX}, {31'd0, bits[i]});
            if (i == 9) chk($sformatf("%s_busy_in_stop", tag), {31'd0, TX_BUSY}, 32'd1);
            @(posedge HCLK); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;

        // Reset state
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_tx", {31'd0, UART_TX}, 32'd1);
        chk("rst_busy", {31'd0, TX_BUSY}, 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        bus_rd(32'h4, 1'b1, 2'b10, rd);
        chk("rst_status", rd, st(0, 1'b0, 1'b0));

        // Single frame 0x55: start edge two edges after the data phase begins
        wq = '{32'h55};
        wr_burst(32'h0, 1'b1);
        chk("f55_pre_start", {31'd0, UART_TX}, 32'd1);
        @(posedge HCLK); #1;
        chk_frame(8'h55, "f55");
        chk("f55_busy_done", {31'd0, TX_BUSY}, 32'd0);
        chk("f55_idle_line", {31'd0, UART_TX}, 32'd1);

        // Back-to-back frames with no gap
        wq = '{32'hA3, 32'h0F};
        wr_burst(32'h0, 1'b1);
        chk_frame(8'hA3, "fa3");
        chk_frame(8'h0F, "f0f");
        chk("b2b_busy_done", {31'd0, TX_BUSY}, 32'd0);

        // 18 consecutive writes: first is popped, 16 fill the FIFO, 18th overflows.
        // Start edge S is two edges after the first address phase; we return at S+16.
        wq.delete();
        for (int i = 0; i < 18; i++) wq.push_back(32'h10 + 32'(i));
        wr_burst(32'h0, 1'b1);
        bus_rd(32'h4, 1'b1, 2'b10, rd);                    // S+17
        chk("ovf_status", rd, 32'h0000_100E);
        chk("ovf_status_model", rd, st(16, 1'b1, 1'b1));
        wq = '{32'h1};
        wr_burst(32'h8, 1'b1);                             // S+19
        bus_rd(32'h4, 1'b1, 2'b11, rd);                    // S+20 (SEQ read)
        chk("ovf_cleared", rd, st(16, 1'b0, 1'b1));

        // Push landing on the edge where STOP ends and the FSM pops (S+160)
        repeat (138) @(posedge HCLK);
        #1;                                                // S+158
        wq = '{32'hEE};
        wr_burst(32'h0, 1'b1);                             // push attempt at S+160
        chk("pop_edge_start_bit", {31'd0, UART_TX}, 32'd0);
        bus_rd(32'h4, 1'b1, 2'b10, rd);                    // S+161
        chk("pop_push_status", rd, st(15, 1'b1, 1'b1));

        // Frame of 0x11 began at S+160; bit1 (0) spans S+192..S+208
        repeat (39) @(posedge HCLK);
        #1;                                                // S+200
        chk("mid_bit_low", {31'd0, UART_TX}, 32'd0);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("async_rst_tx", {31'd0, UART_TX}, 32'd1);
        chk("async_rst_busy", {31'd0, TX_BUSY}, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        bus_rd(32'h4, 1'b1, 2'b10, rd);
        chk("post_rst_status", rd, st(0, 1'b0, 1'b0));
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge HCLK); #1;
            if (UART_TX !== 1'b1) lows++;
        end
        chk("no_residual_frame", 32'(lows), 32'd0);
        chk("post_rst_busy", {31'd0, TX_BUSY}, 32'd0);

        // Reads that must return 0 in the data phase
        bus_rd(32'h4, 1'b0, 2'b10, rd);
        chk("rd_hsel0", rd, 32'd0);
        bus_rd(32'h4, 1'b1, 2'b00, rd);
        chk("rd_trans_idle", rd, 32'd0);
        bus_rd(32'h4, 1'b1, 2'b01, rd);
        chk("rd_trans_busy", rd, 32'd0);
        bus_rd(32'hC, 1'b1, 2'b10, rd);
        chk("rd_off_c", rd, 32'd0);
        bus_rd(32'h0, 1'b1, 2'b10, rd);
        chk("rd_data_reg", rd, 32'd0);
        bus_rd(32'h8, 1'b1, 2'b10, rd);
        chk("rd_ctrl_reg", rd, 32'd0);

        // Writes that must not touch the FIFO
        wq = '{32'h5A};
        wr_burst(32'h0, 1'b0);
        wr_burst(32'hC, 1'b1);
        repeat (4) @(posedge HCLK);
        #1;
        chk("ignored_wr_line", {31'd0, UART_TX}, 32'd1);
        chk("ignored_wr_busy", {31'd0, TX_BUSY}, 32'd0);
        bus_rd(32'h4, 1'b1, 2'b10, rd);
        chk("ignored_wr_status", rd, st(0, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
